// File: rtl/mux_rr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// mux_pkg : shared constants and FSM state type for mux_rr_sequencer
// Revision: 1.0
// ============================================================================
package mux_pkg;
   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      HOLD    = 2'd2
   } mux_seq_state_t;
endpackage
`default_nettype wire

// File: rtl/mux_rr_sequencer_if.sv
`default_nettype none
// ============================================================================
// mux_rr_sequencer_if : request/mux/output bundle around the sequencer
// Optional macro: MUX_SEQ_PARITY_EN adds out_par.  Revision: 1.0
// ============================================================================
interface mux_rr_sequencer_if #(
   parameter int DATA_W = 4
);
   import mux_pkg::*;

   logic [NUM_CH-1:0] req;
   logic [DATA_W-1:0] mux_out;
   logic [SEL_W-1:0]  sel;
   logic [NUM_CH-1:0] grant;
   logic [DATA_W-1:0] out_data;
   logic [SEL_W-1:0]  out_ch;
   logic              out_valid;
   logic              out_ready;
`ifdef MUX_SEQ_PARITY_EN
   logic              out_par;
`endif

   modport master (
      input  req, mux_out, out_ready,
`ifdef MUX_SEQ_PARITY_EN
      output out_par,
`endif
      output sel, grant, out_data, out_ch, out_valid
   );

   modport slave (
      output req, mux_out, out_ready,
`ifdef MUX_SEQ_PARITY_EN
      input  out_par,
`endif
      input  sel, grant, out_data, out_ch, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/mux_rr_sequencer_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational rotating-priority encoder, search starts at ptr
// Revision: 1.0
// ============================================================================
module rr_pick
   import mux_pkg::*;
(
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [SEL_W-1:0]  winner,
   output logic              any
);
   // Walk offsets from farthest to nearest so the nearest requester wins last.
   always_comb begin
      winner = ptr;
      any    = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req[ptr + SEL_W'(i)]) begin
            winner = ptr + SEL_W'(i);
            any    = 1'b1;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/mux_rr_sequencer.sv
`default_nettype none
// ============================================================================
// mux_rr_sequencer : round-robin select driver and capture register for a
// 4-to-1 mux. Optional macro: MUX_SEQ_PARITY_EN adds out_par. Revision: 1.0
// ============================================================================
module mux_rr_sequencer
   import mux_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   mux_rr_sequencer_if.master bus
);
   mux_seq_state_t    state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [SEL_W-1:0]  ptr_q, ptr_d;
   logic [NUM_CH-1:0] grant_q, grant_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0]  out_ch_q, out_ch_d;
   logic              out_valid_q, out_valid_d;
`ifdef MUX_SEQ_PARITY_EN
   logic              out_par_q, out_par_d;
`endif
   logic [SEL_W-1:0]  winner;
   logic              any;

   rr_pick u_rr_pick (
      .req    (bus.req),
      .ptr    (ptr_q),
      .winner (winner),
      .any    (any)
   );

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      ptr_d       = ptr_q;
      grant_d     = '0;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
`ifdef MUX_SEQ_PARITY_EN
      out_par_d   = out_par_q;
`endif
      case (state_q)
         IDLE: begin
            if (any) begin
               sel_d   = winner;
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            out_data_d     = bus.mux_out;
            out_ch_d       = sel_q;
            out_valid_d    = 1'b1;
            grant_d[sel_q] = 1'b1;
            ptr_d          = sel_q + SEL_W'(1);
`ifdef MUX_SEQ_PARITY_EN
            out_par_d      = ^bus.mux_out;
`endif
            state_d        = HOLD;
         end
         HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         ptr_q       <= '0;
         grant_q     <= '0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
`ifdef MUX_SEQ_PARITY_EN
         out_par_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
`ifdef MUX_SEQ_PARITY_EN
         out_par_q   <= out_par_d;
`endif
      end
   end

   assign bus.sel       = sel_q;
   assign bus.grant     = grant_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_valid = out_valid_q;
`ifdef MUX_SEQ_PARITY_EN
   assign bus.out_par   = out_par_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_mux_rr_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mux_rr_sequencer : directed bench with an expected-transfer scoreboard
// Optional macro: MUX_SEQ_PARITY_EN enables parity checks. Revision: 1.0
// ============================================================================
module tb_mux_rr_sequencer;
   typedef struct packed {
      logic [1:0] ch;
      logic [3:0] data;
   } xfer_t;

   logic       clk;
   logic       rst;
   logic [3:0] ch_data [4];
   xfer_t      exp_q [$];
   int         checks;
   int         errors;
   int         cyc;
   int         last_g;
   logic       chk_spacing;

   mux_rr_sequencer_if #(.DATA_W(4)) bus ();

   mux_rr_sequencer #(.DATA_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural stand-in for the downstream 4-to-1 mux.
   assign bus.mux_out = ch_data[bus.sel];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [1:0] ch, input logic [3:0] data);
      xfer_t e;
      e.ch   = ch;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic do_xfer(input logic [3:0] r);
      bus.req = r;
      @(posedge clk);
      #1 bus.req = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Scoreboard: every grant pulse must match the oldest expected transfer.
   always @(negedge clk) begin
      cyc++;
      if (bus.grant !== 4'b0000) begin
         if (exp_q.size() == 0) begin
            check("unexpected_grant", {4'h0, bus.grant}, 8'h00);
         end else begin
            xfer_t e;
            e = exp_q.pop_front();
            check("sb_out_ch", {6'h0, bus.out_ch}, {6'h0, e.ch});
            check("sb_out_data", {4'h0, bus.out_data}, {4'h0, e.data});
            check("sb_grant", {4'h0, bus.grant}, 8'(4'b0001 << e.ch));
            check("sb_out_valid", {7'h0, bus.out_valid}, 8'h01);
`ifdef MUX_SEQ_PARITY_EN
            check("sb_out_par", {7'h0, bus.out_par}, {7'h0, ^e.data});
`endif
         end
         if (chk_spacing && last_g >= 0)
            check("xfer_spacing", 8'(cyc - last_g), 8'd3);
         last_g = cyc;
      end
      if (!chk_spacing) last_g = -1;
   end

   initial begin
      checks      = 0;
      errors      = 0;
      cyc         = 0;
      last_g      = -1;
      chk_spacing = 1'b0;
      ch_data[0]  = 4'h5;
      ch_data[1]  = 4'h6;
      ch_data[2]  = 4'h9;
      ch_data[3]  = 4'h3;
      rst           = 1'b1;
      bus.req       = 4'b1111;
      bus.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check("reset_sel", {6'h0, bus.sel}, 8'h00);
      check("reset_out_valid", {7'h0, bus.out_valid}, 8'h00);
      check("reset_grant", {4'h0, bus.grant}, 8'h00);
      check("reset_out_data", {4'h0, bus.out_data}, 8'h00);

      // All channels requesting from ptr=0, consumer always ready.
      rst         = 1'b0;
      chk_spacing = 1'b1;
      push(2'd0, 4'h5);
      push(2'd1, 4'h6);
      push(2'd2, 4'h9);
      push(2'd3, 4'h3);
      push(2'd0, 4'h5);
      repeat (13) @(posedge clk);
      #1 bus.req = 4'b0000;
      repeat (2) @(posedge clk);
      #1 chk_spacing = 1'b0;
      check("all_valid_dropped", {7'h0, bus.out_valid}, 8'h00);

      // Single channel 2 (ptr is 1 here).
      ch_data[2] = 4'hA;
      push(2'd2, 4'hA);
      bus.req = 4'b0100;
      @(posedge clk);
      #1 bus.req = 4'b0000;
      check("single_sel", {6'h0, bus.sel}, 8'h02);
      @(posedge clk);
      #1;
      check("single_out_data", {4'h0, bus.out_data}, 8'h0A);
      check("single_out_ch", {6'h0, bus.out_ch}, 8'h02);
      check("single_grant", {4'h0, bus.grant}, 8'h04);
      @(posedge clk);
      #1;

      // ptr must now be 3, so channel 3 wins over all others.
      push(2'd3, 4'h3);
      do_xfer(4'b1111);

      // Backpressure: ptr wrapped to 0, channel 0 held for 5 HOLD cycles.
      bus.out_ready = 1'b0;
      push(2'd0, 4'h5);
      bus.req = 4'b0001;
      @(posedge clk);
      #1 bus.req = 4'b0000;
      @(posedge clk);
      #1;
      check("bp_valid_first", {7'h0, bus.out_valid}, 8'h01);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         check("bp_valid_hold", {7'h0, bus.out_valid}, 8'h01);
         check("bp_data_hold", {4'h0, bus.out_data}, 8'h05);
         check("bp_grant_low", {4'h0, bus.grant}, 8'h00);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_valid_fall", {7'h0, bus.out_valid}, 8'h00);

      // Reset while a word is held (ptr is 1).
      bus.out_ready = 1'b0;
      push(2'd1, 4'h6);
      bus.req = 4'b0010;
      @(posedge clk);
      #1 bus.req = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_valid_pre", {7'h0, bus.out_valid}, 8'h01);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_hold_valid", {7'h0, bus.out_valid}, 8'h00);
      check("rst_hold_data", {4'h0, bus.out_data}, 8'h00);
      check("rst_hold_grant", {4'h0, bus.grant}, 8'h00);
      check("rst_hold_sel", {6'h0, bus.sel}, 8'h00);
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

`ifdef MUX_SEQ_PARITY_EN
      ch_data[0] = 4'b1011;
      push(2'd0, 4'b1011);
      do_xfer(4'b0001);
      check("par_1011", {7'h0, bus.out_par}, 8'h01);
      ch_data[0] = 4'b0110;
      push(2'd0, 4'b0110);
      do_xfer(4'b0001);
      check("par_0110", {7'h0, bus.out_par}, 8'h00);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 8'(exp_q.size()), 8'h00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
